// File: rtl/div_if.sv
// Request/response bundle between execute-stage control and the iterative divider.
// Control drives the request side; the divider drives busy/done/result.
interface div_if;
   logic        start;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [1:0]  div_fun;
   logic        busy;
   logic        done;
   logic [31:0] result;

   modport master (
      output start, srcA, srcB, div_fun,
      input  busy, done, result
   );

   modport slave (
      input  start, srcA, srcB, div_fun,
      output busy, done, result
   );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU: restoring division on magnitudes, one quotient bit
// per cycle, sign fix-up afterwards; divide-by-zero and signed overflow bypass the loop.
module div_unit (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state_reg;
   logic [31:0] rem_reg;
   logic [31:0] quo_reg;
   logic [31:0] dvs_reg;
   logic [4:0]  cnt_reg;
   logic [1:0]  fun_reg;
   logic        sign_a_reg;
   logic        sign_b_reg;
   logic        busy_reg;
   logic        done_reg;
   logic [31:0] result_reg;

   logic        op_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic        div_zero;
   logic        overflow;
   logic [31:0] bypass_next;
   logic [32:0] trial;
   logic        no_borrow;
   logic [31:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] result_next;

   // Request-side decode, only meaningful on an accepting edge in IDLE.
   always_comb begin
      op_signed = ~bus.div_fun[0];
      a_neg     = op_signed & bus.srcA[31];
      b_neg     = op_signed & bus.srcB[31];
      a_abs     = a_neg ? (32'd0 - bus.srcA) : bus.srcA;
      b_abs     = b_neg ? (32'd0 - bus.srcB) : bus.srcB;
      div_zero  = (bus.srcB == 32'd0);
      overflow  = op_signed && (bus.srcA == 32'h8000_0000) && (bus.srcB == 32'hFFFF_FFFF);
      if (div_zero)
         bypass_next = bus.div_fun[1] ? bus.srcA : 32'hFFFF_FFFF;
      else
         bypass_next = bus.div_fun[1] ? 32'h0000_0000 : 32'h8000_0000;
   end

   // Partial remainder stays below the divisor, so bit 32 of the 33-bit trial is the borrow.
   always_comb begin
      trial     = {rem_reg, quo_reg[31]} - {1'b0, dvs_reg};
      no_borrow = ~trial[32];
      rem_next  = no_borrow ? trial[31:0] : {rem_reg[30:0], quo_reg[31]};
      quo_next  = {quo_reg[30:0], no_borrow};
   end

   always_comb begin
      quo_fix     = (~fun_reg[0] & (sign_a_reg ^ sign_b_reg)) ? (32'd0 - quo_reg) : quo_reg;
      rem_fix     = (~fun_reg[0] & sign_a_reg) ? (32'd0 - rem_reg) : rem_reg;
      result_next = fun_reg[1] ? rem_fix : quo_fix;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         rem_reg    <= 32'd0;
         quo_reg    <= 32'd0;
         dvs_reg    <= 32'd0;
         cnt_reg    <= 5'd0;
         fun_reg    <= 2'd0;
         sign_a_reg <= 1'b0;
         sign_b_reg <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         result_reg <= 32'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  fun_reg    <= bus.div_fun;
                  sign_a_reg <= a_neg;
                  sign_b_reg <= b_neg;
                  if (div_zero || overflow) begin
                     result_reg <= bypass_next;
                     done_reg   <= 1'b1;
                     state_reg  <= DONE;
                  end else begin
                     rem_reg   <= 32'd0;
                     quo_reg   <= a_abs;
                     dvs_reg   <= b_abs;
                     cnt_reg   <= 5'd0;
                     busy_reg  <= 1'b1;
                     state_reg <= CALC;
                  end
               end
            end
            CALC: begin
               rem_reg <= rem_next;
               quo_reg <= quo_next;
               cnt_reg <= cnt_reg + 5'd1;
               if (cnt_reg == 5'd31)
                  state_reg <= FIX;
            end
            FIX: begin
               result_reg <= result_next;
               busy_reg   <= 1'b0;
               done_reg   <= 1'b1;
               state_reg  <= DONE;
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_reg;
   assign bus.done   = done_reg;
   assign bus.result = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, random ops against an arithmetic model,
// and hand-written sequences for ignored starts, reset mid-operation and back-to-back issue.
module tb_div_unit;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   div_if dif ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  f;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // RISC-V divide semantics straight from the ISA rules, using wide integer arithmetic.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] f);
      int     ia;
      int     ib;
      longint la;
      longint lb;
      longint q;
      longint r;
      if (b == 32'd0)
         return f[1] ? a : 32'hFFFF_FFFF;
      if (f[0])
         return f[1] ? (a % b) : (a / b);
      ia = a;
      ib = b;
      la = ia;
      lb = ib;
      q  = la / lb;
      r  = la % lb;
      return f[1] ? r[31:0] : q[31:0];
   endfunction

   function automatic bit is_bypass(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] f);
      return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Drives one request; returns at the falling edge just after the accepting edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
      @(negedge clk);
      dif.start   = 1'b1;
      dif.srcA    = a;
      dif.srcB    = b;
      dif.div_fun = f;
      @(negedge clk);
      dif.start = 1'b0;
   endtask

   // Called at the first falling edge after accept; lat counts cycles until done is seen.
   task automatic wait_done(output logic [31:0] res, output int lat, output int busy_cnt,
                            output int overlap);
      lat      = 1;
      busy_cnt = 0;
      overlap  = 0;
      while (1) begin
         if (dif.busy === 1'b1 && dif.done === 1'b1) overlap++;
         if (dif.done === 1'b1) break;
         if (dif.busy === 1'b1) busy_cnt++;
         if (lat >= 100) break;
         @(negedge clk);
         lat++;
      end
      res = dif.result;
   endtask

   task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] f, input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int          lat;
      int          bc;
      int          ov;
      issue(a, b, f);
      wait_done(res, lat, bc, ov);
      $display("[TB] %s fun=%0d a=%h b=%h -> result=%h latency=%0d", name, f, a, b, res, lat);
      chk({name, " result"}, res, exp);
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " busy cycles"}, bc, (exp_lat == 1) ? 0 : 33);
      chk({name, " busy&done overlap"}, ov, 0);
   endtask

   function automatic logic [31:0] pick(input int sel);
      logic [31:0] v;
      case (sel)
         0: v = $urandom_range(0, 255);
         1: v = 32'hFFFF_FFFF - $urandom_range(0, 255);
         2: v = 32'h8000_0000;
         3: v = 32'hFFFF_FFFF;
         4: v = 32'd0;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      logic [31:0] res;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  f;
      logic [31:0] exp;
      int          lat;
      int          bc;
      int          ov;

      tests = 0;
      fails = 0;
      rst         = 1'b1;
      dif.start   = 1'b0;
      dif.srcA    = 32'd0;
      dif.srcB    = 32'd0;
      dif.div_fun = 2'd0;

      vecs[0] = '{32'd100,        32'd7,          2'b01, 32'd14,         34};
      vecs[1] = '{32'd100,        32'd7,          2'b11, 32'd2,          34};
      vecs[2] = '{32'hFFFF_FFF9,  32'd2,          2'b00, 32'hFFFF_FFFD,  34};
      vecs[3] = '{32'hFFFF_FFF9,  32'd2,          2'b10, 32'hFFFF_FFFF,  34};
      vecs[4] = '{32'hFFFF_FFFF,  32'd1,          2'b01, 32'hFFFF_FFFF,  34};
      vecs[5] = '{32'd1234,       32'd0,          2'b00, 32'hFFFF_FFFF,  1};
      vecs[6] = '{32'd1234,       32'd0,          2'b11, 32'd1234,       1};
      vecs[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  2'b00, 32'h8000_0000,  1};
      vecs[8] = '{32'h8000_0000,  32'hFFFF_FFFF,  2'b10, 32'h0000_0000,  1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", dif.busy, 0);
      chk("reset done", dif.done, 0);
      chk("reset result", dif.result, 0);
      rst = 1'b0;

      // Reset wins over a simultaneous start.
      dif.start = 1'b1; dif.srcA = 32'd100; dif.srcB = 32'd7; dif.div_fun = 2'b01;
      rst = 1'b1;
      @(negedge clk);
      chk("rst+start busy", dif.busy, 0);
      chk("rst+start done", dif.done, 0);
      rst = 1'b0;
      dif.start = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].exp,
                   vecs[i].lat);
         @(negedge clk);
         chk($sformatf("vec%0d hold", i), dif.result, vecs[i].exp);
         chk($sformatf("vec%0d done pulse", i), dif.done, 0);
      end

      for (int i = 0; i < 40; i++) begin
         a = pick($urandom_range(0, 8));
         b = pick($urandom_range(0, 8));
         f = 2'($urandom_range(0, 3));
         run_check($sformatf("rnd%0d", i), a, b, f, ref_div(a, b, f),
                   is_bypass(a, b, f) ? 1 : 34);
      end

      // Second start mid-operation and operand changes after accept are ignored.
      issue(32'd50, 32'd5, 2'b01);
      repeat (9) @(negedge clk);
      dif.start = 1'b1; dif.srcA = 32'd9; dif.srcB = 32'd3;
      @(negedge clk);
      dif.start = 1'b0; dif.srcA = 32'd77;
      wait_done(res, lat, bc, ov);
      $display("[TB] midstart fun=1 a=50 b=5 -> result=%h latency=%0d", res, lat + 10);
      chk("midstart result", res, 32'd10);
      chk("midstart latency", lat + 10, 34);

      // Reset in the middle of an operation.
      issue(32'd1000, 32'd3, 2'b01);
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst busy", dif.busy, 0);
      chk("midrst done", dif.done, 0);
      chk("midrst result", dif.result, 0);
      rst = 1'b0;
      dif.start = 1'b1; dif.srcA = 32'd9; dif.srcB = 32'd3; dif.div_fun = 2'b01;
      @(negedge clk);
      dif.start = 1'b0;
      chk("postrst accept", dif.busy, 1);
      wait_done(res, lat, bc, ov);
      $display("[TB] postrst fun=1 a=9 b=3 -> result=%h latency=%0d", res, lat);
      chk("postrst result", res, 32'd3);
      chk("postrst latency", lat, 34);

      // Start held from the DONE cycle: ignored there, accepted on the following edge.
      dif.start = 1'b1; dif.srcA = 32'd100; dif.srcB = 32'd7; dif.div_fun = 2'b01;
      @(negedge clk);
      chk("b2b ignored in done", dif.busy, 0);
      chk("b2b no done", dif.done, 0);
      @(negedge clk);
      dif.start = 1'b0;
      chk("b2b accepted", dif.busy, 1);
      wait_done(res, lat, bc, ov);
      $display("[TB] b2b fun=1 a=100 b=7 -> result=%h latency=%0d", res, lat);
      chk("b2b result", res, 32'd14);
      chk("b2b latency", lat, 34);
      chk("b2b busy cycles", bc, 33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
